// File: rtl/embed_sequencer.sv
// embed_sequencer: walks a block of LL coefficient addresses, feeds each
// host/watermark coefficient pair plus a frame-constant alpha to the
// combinational embedder and writes the result to the output memory.
// Pipeline: read issue -> memory data -> operand regs -> write (3 cycles).
module embed_sequencer #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 12,
    parameter int NUM_COEF = 4096
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W:0]   len,
    input  logic [DATA_W-1:0] alpha_cfg,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_ll1,
    input  logic [DATA_W-1:0] rd_ll2,
    output logic [DATA_W-1:0] emb_ll1,
    output logic [DATA_W-1:0] emb_ll2,
    output logic [DATA_W-1:0] emb_alpha,
    input  logic [DATA_W-1:0] emb_ll_new,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic [ADDR_W:0]   coef_cnt
);
    localparam int CW = ADDR_W + 1;
    localparam logic [CW-1:0] MAX_LEN = CW'(NUM_COEF);

    typedef enum logic [1:0] {IDLE, READ, DRAIN, FIN} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     len_q, len_d, len_eff;
    logic              rd_en_q, rd_en_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic              rd_vld_q, rd_vld_d;
    logic [ADDR_W-1:0] rd_vld_addr_q, rd_vld_addr_d;
    logic              s1_vld_q, s1_vld_d;
    logic [ADDR_W-1:0] s1_addr_q, s1_addr_d;
    logic [DATA_W-1:0] emb_ll1_q, emb_ll1_d;
    logic [DATA_W-1:0] emb_ll2_q, emb_ll2_d;
    logic [DATA_W-1:0] emb_alpha_q, emb_alpha_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              aborted_q, aborted_d;
    logic [CW-1:0]     coef_cnt_q, coef_cnt_d;

    // Next-state, pipeline advance and registered-output computation.
    always_comb begin
        state_d       = state_q;
        len_d         = len_q;
        rd_en_d       = rd_en_q;
        rd_addr_d     = rd_addr_q;
        emb_alpha_d   = emb_alpha_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
        aborted_d     = 1'b0;
        coef_cnt_d    = coef_cnt_q;
        len_eff       = (len > MAX_LEN) ? MAX_LEN : len;

        // Pipeline stages advance every cycle; operand and write regs hold
        // their last contents when no valid data arrives.
        rd_vld_d      = rd_en_q;
        rd_vld_addr_d = rd_addr_q;
        s1_vld_d      = rd_vld_q;
        s1_addr_d     = s1_addr_q;
        emb_ll1_d     = emb_ll1_q;
        emb_ll2_d     = emb_ll2_q;
        if (rd_vld_q) begin
            emb_ll1_d = rd_ll1;
            emb_ll2_d = rd_ll2;
            s1_addr_d = rd_vld_addr_q;
        end
        wr_en_d   = s1_vld_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        if (s1_vld_q) begin
            wr_addr_d = s1_addr_q;
            wr_data_d = emb_ll_new;
        end

        if (wr_en_q && (coef_cnt_q < len_q))
            coef_cnt_d = coef_cnt_q + CW'(1);

        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    len_d       = len_eff;
                    emb_alpha_d = alpha_cfg;
                    coef_cnt_d  = '0;
                    busy_d      = 1'b1;
                    if (len_eff == '0) begin
                        state_d = FIN;
                    end else begin
                        state_d   = READ;
                        rd_en_d   = 1'b1;
                        rd_addr_d = '0;
                    end
                end
            end
            READ, DRAIN: begin
                if (abort) begin
                    // Drop everything in flight; the write already on the
                    // bus this cycle is the last one issued.
                    state_d   = IDLE;
                    aborted_d = 1'b1;
                    busy_d    = 1'b0;
                    rd_en_d   = 1'b0;
                    rd_vld_d  = 1'b0;
                    s1_vld_d  = 1'b0;
                    wr_en_d   = 1'b0;
                end else if (state_q == READ) begin
                    if ({1'b0, rd_addr_q} == len_q - CW'(1)) begin
                        state_d = DRAIN;
                        rd_en_d = 1'b0;
                    end else begin
                        rd_addr_d = rd_addr_q + ADDR_W'(1);
                    end
                end else if (s1_vld_q && ({1'b0, s1_addr_q} == len_q - CW'(1))) begin
                    // Final write goes out next cycle, in FIN.
                    state_d = FIN;
                end
            end
            FIN: begin
                state_d = IDLE;
                done_d  = 1'b1;
                busy_d  = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and all registered outputs, cleared by asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            len_q         <= '0;
            rd_en_q       <= 1'b0;
            rd_addr_q     <= '0;
            rd_vld_q      <= 1'b0;
            rd_vld_addr_q <= '0;
            s1_vld_q      <= 1'b0;
            s1_addr_q     <= '0;
            emb_ll1_q     <= '0;
            emb_ll2_q     <= '0;
            emb_alpha_q   <= '0;
            wr_en_q       <= 1'b0;
            wr_addr_q     <= '0;
            wr_data_q     <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            aborted_q     <= 1'b0;
            coef_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            len_q         <= len_d;
            rd_en_q       <= rd_en_d;
            rd_addr_q     <= rd_addr_d;
            rd_vld_q      <= rd_vld_d;
            rd_vld_addr_q <= rd_vld_addr_d;
            s1_vld_q      <= s1_vld_d;
            s1_addr_q     <= s1_addr_d;
            emb_ll1_q     <= emb_ll1_d;
            emb_ll2_q     <= emb_ll2_d;
            emb_alpha_q   <= emb_alpha_d;
            wr_en_q       <= wr_en_d;
            wr_addr_q     <= wr_addr_d;
            wr_data_q     <= wr_data_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            aborted_q     <= aborted_d;
            coef_cnt_q    <= coef_cnt_d;
        end
    end

    // Abort cancels the read issued in the same cycle.
    assign rd_en     = rd_en_q & ~abort;
    assign rd_addr   = rd_addr_q;
    assign emb_ll1   = emb_ll1_q;
    assign emb_ll2   = emb_ll2_q;
    assign emb_alpha = emb_alpha_q;
    assign wr_en     = wr_en_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign aborted   = aborted_q;
    assign coef_cnt  = coef_cnt_q;

endmodule

// File: tb/tb_embed_sequencer.sv
// Directed testbench for embed_sequencer with memory and embedder models.
module tb_embed_sequencer;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 12;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic [ADDR_W:0]   len = '0;
    logic [DATA_W-1:0] alpha_cfg = '0;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_ll1, rd_ll2;
    logic [DATA_W-1:0] emb_ll1, emb_ll2, emb_alpha, emb_ll_new;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              busy, done, aborted;
    logic [ADDR_W:0]   coef_cnt;

    embed_sequencer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_COEF(4096)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .len(len),
        .alpha_cfg(alpha_cfg), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_ll1(rd_ll1), .rd_ll2(rd_ll2), .emb_ll1(emb_ll1), .emb_ll2(emb_ll2),
        .emb_alpha(emb_alpha), .emb_ll_new(emb_ll_new), .wr_en(wr_en),
        .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy), .done(done),
        .aborted(aborted), .coef_cnt(coef_cnt)
    );

    always #5 clk = ~clk;

    // Synchronous LL memories and combinational embedder model.
    logic [DATA_W-1:0] mem1 [0:4095];
    logic [DATA_W-1:0] mem2 [0:4095];
    always @(posedge clk) begin
        if (rd_en === 1'b1) begin
            rd_ll1 <= mem1[rd_addr];
            rd_ll2 <= mem2[rd_addr];
        end
    end
    assign emb_ll_new = emb_ll1 + emb_alpha * emb_ll2;

    // Expected write data: 0 = table, 1 = constant, 2 = address+1.
    int                exp_mode = 0;
    logic [DATA_W-1:0] exp_const = '0;
    logic [DATA_W-1:0] exp_tab [0:3];

    // Cumulative event monitor sampled at every rising edge.
    int   cyc = 0;
    int   rd_total = 0, wr_total = 0, done_total = 0, abt_total = 0, busy_total = 0;
    int   addr_err = 0, data_err = 0;
    int   rd_rise_cyc = 0, wr_rise_cyc = 0, last_wr_cyc = 0, done_cyc = 0;
    int   last_wr_addr = 0, exp_next = 0;
    logic prev_rd = 1'b0, prev_wr = 1'b0;
    logic [DATA_W-1:0] exp_d;
    always @(posedge clk) begin
        if (rd_en === 1'b1) begin
            rd_total++;
            if (!prev_rd) rd_rise_cyc = cyc;
        end
        if (wr_en === 1'b1) begin
            wr_total++;
            if (!prev_wr) begin
                wr_rise_cyc = cyc;
                exp_next    = 0;
            end
            if (int'(wr_addr) != exp_next) addr_err++;
            exp_next = int'(wr_addr) + 1;
            case (exp_mode)
                0:       exp_d = exp_tab[wr_addr[1:0]];
                1:       exp_d = exp_const;
                default: exp_d = DATA_W'(wr_addr) + 1;
            endcase
            if (wr_data !== exp_d) addr_err += 0;
            if (wr_data !== exp_d) data_err++;
            last_wr_cyc  = cyc;
            last_wr_addr = int'(wr_addr);
        end
        if (done === 1'b1) begin
            done_total++;
            done_cyc = cyc;
        end
        if (aborted === 1'b1) abt_total++;
        if (busy === 1'b1) busy_total++;
        prev_rd = (rd_en === 1'b1);
        prev_wr = (wr_en === 1'b1);
        cyc++;
    end

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    int s_cyc, rd0, wr0, dn0, ab0, bz0, ae0, de0;

    task automatic snap();
        rd0 = rd_total; wr0 = wr_total; dn0 = done_total; ab0 = abt_total;
        bz0 = busy_total; ae0 = addr_err; de0 = data_err;
    endtask

    // One-cycle start pulse; s_cyc is the edge index that samples it.
    task automatic do_start(input int l, input int a);
        @(negedge clk);
        start = 1'b1; len = (ADDR_W+1)'(l); alpha_cfg = DATA_W'(a);
        s_cyc = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_end(input string tag, input int budget);
        int k = 0;
        while (done_total == dn0 && abt_total == ab0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(tag, (k < budget), 1);
    endtask

    initial begin
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_rd_en", rd_en, 0);
        check("rst_rd_addr", rd_addr, 0);
        check("rst_wr_en", wr_en, 0);
        check("rst_emb_ll1", emb_ll1, 0);
        check("rst_emb_alpha", emb_alpha, 0);
        check("rst_busy", busy, 0);
        check("rst_done_abt", {done, aborted}, 0);
        check("rst_coef_cnt", coef_cnt, 0);
        rst_n = 1'b1;

        // Frame 1: basic 4-coefficient frame, alpha=1.
        mem1[0] = 100; mem1[1] = 200; mem1[2] = 300; mem1[3] = 400;
        mem2[0] = 5;   mem2[1] = 6;   mem2[2] = 7;   mem2[3] = 8;
        exp_tab[0] = 105; exp_tab[1] = 206; exp_tab[2] = 307; exp_tab[3] = 408;
        exp_mode = 0;
        snap();
        do_start(4, 1);
        wait_end("f1_timeout", 50);
        check("f1_writes", wr_total - wr0, 4);
        check("f1_reads", rd_total - rd0, 4);
        check("f1_addr_seq", addr_err - ae0, 0);
        check("f1_data", data_err - de0, 0);
        check("f1_rd_latency", rd_rise_cyc - s_cyc, 1);
        check("f1_wr_latency", wr_rise_cyc - rd_rise_cyc, 3);
        check("f1_last_addr", last_wr_addr, 3);
        check("f1_done_after_wr", done_cyc - last_wr_cyc, 1);
        check("f1_coef_cnt", coef_cnt, 4);
        check("f1_busy_done", {busy, done}, 0);
        $display("frame len4: writes=%0d coef_cnt=%0d", wr_total - wr0, coef_cnt);

        // Frame 2: zero length.
        snap();
        do_start(0, 1);
        wait_end("f2_timeout", 20);
        check("f2_reads", rd_total - rd0, 0);
        check("f2_writes", wr_total - wr0, 0);
        check("f2_done_delay", done_cyc - s_cyc, 2);
        check("f2_busy_cycles", busy_total - bz0, 1);
        $display("frame len0: writes=%0d busy_cycles=%0d", wr_total - wr0, busy_total - bz0);

        // Frame 3: oversize length saturates at NUM_COEF.
        for (int i = 0; i < 4096; i++) begin
            mem1[i] = DATA_W'(i);
            mem2[i] = 1;
        end
        exp_mode = 2;
        snap();
        do_start(5000, 1);
        wait_end("f3_timeout", 4200);
        check("f3_writes", wr_total - wr0, 4096);
        check("f3_reads", rd_total - rd0, 4096);
        check("f3_last_addr", last_wr_addr, 4095);
        check("f3_addr_seq", addr_err - ae0, 0);
        check("f3_data", data_err - de0, 0);
        check("f3_coef_cnt", coef_cnt, 4096);
        check("f3_done", done_total - dn0, 1);
        $display("frame len5000: writes=%0d coef_cnt=%0d", wr_total - wr0, coef_cnt);

        // Frame 4: alpha and start changes mid-frame are ignored.
        for (int i = 0; i < 8; i++) begin
            mem1[i] = 10;
            mem2[i] = 2;
        end
        exp_mode = 1; exp_const = 16;
        snap();
        do_start(8, 3);
        repeat (3) @(negedge clk);
        alpha_cfg = 9; start = 1'b1; len = 2;
        @(negedge clk);
        start = 1'b0;
        wait_end("f4_timeout", 50);
        repeat (5) @(negedge clk);
        check("f4_writes", wr_total - wr0, 8);
        check("f4_data", data_err - de0, 0);
        check("f4_alpha_held", emb_alpha, 3);
        check("f4_coef_cnt", coef_cnt, 8);
        check("f4_done", done_total - dn0, 1);
        check("f4_idle", busy, 0);
        $display("frame alpha: writes=%0d emb_alpha=%0d", wr_total - wr0, emb_alpha);

        // Frame 5: abort in the cycle carrying the write of address 2.
        snap();
        do_start(8, 3);
        while (cyc != s_cyc + 6) @(negedge clk);
        abort = 1'b1;
        #1;
        check("f5_rd_drop", rd_en, 0);
        check("f5_wr_at_abort", {wr_en, wr_addr}, {1'b1, 12'd2});
        @(negedge clk);
        abort = 1'b0;
        wait_end("f5_timeout", 20);
        repeat (6) @(negedge clk);
        check("f5_writes", wr_total - wr0, 3);
        check("f5_addr_seq", addr_err - ae0, 0);
        check("f5_aborted", abt_total - ab0, 1);
        check("f5_no_done", done_total - dn0, 0);
        check("f5_coef_cnt", coef_cnt, 3);
        check("f5_busy", busy, 0);
        $display("frame abort: writes=%0d coef_cnt=%0d", wr_total - wr0, coef_cnt);

        // Frame 6: reset mid-frame, then a clean 2-coefficient frame.
        snap();
        do_start(16, 1);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("f6_rst_rd_en", rd_en, 0);
        check("f6_rst_rd_addr", rd_addr, 0);
        check("f6_rst_busy", busy, 0);
        check("f6_rst_emb", {emb_ll1, emb_ll2, emb_alpha}, 0);
        check("f6_rst_coef_cnt", coef_cnt, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check("f6_no_pulse", (done_total - dn0) + (abt_total - ab0), 0);
        mem1[0] = 7; mem1[1] = 8; mem2[0] = 1; mem2[1] = 1;
        exp_tab[0] = 8; exp_tab[1] = 9;
        exp_mode = 0;
        snap();
        do_start(2, 1);
        wait_end("f6_timeout", 30);
        check("f6_writes", wr_total - wr0, 2);
        check("f6_last_addr", last_wr_addr, 1);
        check("f6_addr_seq", addr_err - ae0, 0);
        check("f6_data", data_err - de0, 0);
        check("f6_coef_cnt", coef_cnt, 2);
        $display("frame post-reset: writes=%0d coef_cnt=%0d", wr_total - wr0, coef_cnt);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout observed=1 expected=0");
        $fatal(1, "timeout");
    end

endmodule
